// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the pipelined LEGv8 core.
//
// Owns the fetch PC, drives a req/ack instruction-memory port and the IF/ID
// pipeline register. A load-use stall that lands on the same cycle as an ack
// parks that instruction in a one-entry hold buffer. A taken branch from MEM
// redirects the PC and squashes whatever is in flight.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   stall_i                        hazard-unit stall (hold PC and IF/ID)
//   branch_taken_i/branch_target_i redirect from MEM
//   imem_req_o/imem_addr_o         fetch request and address (registered only)
//   imem_ack_i/imem_rdata_i        fetch response for the current address
//   pc_o                           current fetch PC
//   if_id_valid_o/pc_o/instr_o     IF/ID register (valid=0 is a bubble)
//   if_id_opcode_o                 if_id_instr_o[31:21], to the control unit
//
// INSTR_WIDTH must be 32: the opcode field is taken from bits [31:21].
module if_stage #(
   parameter int unsigned          PC_WIDTH    = 64,
   parameter int unsigned          INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall_i,
   input  logic                   branch_taken_i,
   input  logic [PC_WIDTH-1:0]    branch_target_i,
   output logic                   imem_req_o,
   output logic [PC_WIDTH-1:0]    imem_addr_o,
   input  logic                   imem_ack_i,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   output logic [PC_WIDTH-1:0]    pc_o,
   output logic                   if_id_valid_o,
   output logic [PC_WIDTH-1:0]    if_id_pc_o,
   output logic [INSTR_WIDTH-1:0] if_id_instr_o,
   output logic [10:0]            if_id_opcode_o
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} fetchStateE;

   typedef struct packed {
      logic [PC_WIDTH-1:0]    pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fetchEntryT;

   fetchStateE             state, stateNext;
   logic [PC_WIDTH-1:0]    pc;
   fetchEntryT             holdBuf;
   logic                   ifIdValid;
   logic [PC_WIDTH-1:0]    ifIdPc;
   logic [INSTR_WIDTH-1:0] ifIdInstr;

   // Datapath strobes. A redirect wins over everything, so every strobe that
   // would consume ack data or the hold buffer is masked by branch_taken_i.
   logic fetchAccept, loadDirect, loadBuf, drainBuf, bubble;

   always_comb begin
      fetchAccept = (state == REQ) && imem_ack_i && !branch_taken_i;
      loadDirect  = fetchAccept && !stall_i;
      loadBuf     = fetchAccept && stall_i;
      drainBuf    = (state == HOLD) && !stall_i && !branch_taken_i;
      bubble      = branch_taken_i || ((state == REQ) && !imem_ack_i && !stall_i);
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      stateNext = state;
      if (branch_taken_i) begin
         stateNext = REQ;
      end else begin
         case (state)
            IDLE:    stateNext = REQ;
            REQ:     if (imem_ack_i && stall_i) stateNext = HOLD;
            HOLD:    if (!stall_i) stateNext = REQ;
            default: stateNext = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // Request depends on state alone, so no input reaches imem_req_o.
   always_comb begin
      imem_req_o = (state == REQ);
   end

   // ---------------- PC, hold buffer, IF/ID ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         holdBuf   <= '0;
         ifIdValid <= 1'b0;
         ifIdPc    <= '0;
         ifIdInstr <= '0;
      end else begin
         // pc + 4 wraps naturally at 2^PC_WIDTH; targets are used unaligned.
         if (branch_taken_i)   pc <= branch_target_i;
         else if (fetchAccept) pc <= pc + PC_WIDTH'(4);

         if (loadBuf) holdBuf <= '{pc: pc, instr: imem_rdata_i};

         // On a redirect only valid is cleared; pc/instr may stay stale.
         if (loadDirect) begin
            ifIdValid <= 1'b1;
            ifIdPc    <= pc;
            ifIdInstr <= imem_rdata_i;
         end else if (drainBuf) begin
            ifIdValid <= 1'b1;
            ifIdPc    <= holdBuf.pc;
            ifIdInstr <= holdBuf.instr;
         end else if (bubble) begin
            ifIdValid <= 1'b0;
         end
      end
   end

   assign imem_addr_o    = pc;
   assign pc_o           = pc;
   assign if_id_valid_o  = ifIdValid;
   assign if_id_pc_o     = ifIdPc;
   assign if_id_instr_o  = ifIdInstr;
   assign if_id_opcode_o = ifIdInstr[31:21];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined LEGv8 core.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Drives the IF/ID pipeline register, whose opcode field (instr[31:21]) feeds the control unit in ID.
- Handles load-use stalls from the hazard unit via a one-entry hold buffer, and taken-branch redirects from MEM via flush.

Parameters:
- PC_WIDTH, 64, width of PC and all address ports.
- INSTR_WIDTH, 32, instruction word width; must be 32.
- RESET_PC, 64'h0, PC value loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-unit stall; hold IF/ID and PC.
- branch_taken_i  in  1  taken-branch redirect from MEM stage.
- branch_target_i  in  PC_WIDTH  redirect address.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_WIDTH  fetch address.
- imem_ack_i  in  1  imem_rdata_i valid for the current imem_addr_o.
- imem_rdata_i  in  INSTR_WIDTH  fetched instruction.
- pc_o  out  PC_WIDTH  current fetch PC.
- if_id_valid_o  out  1  IF/ID holds a real instruction; 0 = bubble.
- if_id_pc_o  out  PC_WIDTH  PC of the IF/ID instruction.
- if_id_instr_o  out  INSTR_WIDTH  IF/ID instruction.
- if_id_opcode_o  out  11  equals if_id_instr_o[31:21]; goes to the control unit.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE, pc = RESET_PC.
  - imem_req_o = 0, if_id_valid_o = 0, if_id_pc_o = 0, if_id_instr_o = 0.
  - Hold buffer empty.
- Reset asserted mid-operation clears all of the above immediately; any in-flight ack is ignored.
- imem_req_o and imem_addr_o (= pc) are decoded from registered state only; no combinational path from any input to them.
- Memory contract:
  - ack may arrive in any cycle with req=1, including the first cycle.
  - A change of imem_addr_o aborts the prior request.
- FSM states:
  - IDLE: req=0. Next state REQ, unconditionally. Exists to give one clean cycle after reset.
  - REQ: req=1, addr=pc.
    - ack & !stall_i: IF/ID <= {valid=1, pc, rdata}; pc <= pc+4; stay in REQ. Gives back-to-back fetch, 1 instr/cycle with zero-wait memory.
    - ack & stall_i: buffer <= {pc, rdata}; pc <= pc+4; go to HOLD. IF/ID holds.
    - !ack & !stall_i: if_id_valid_o <= 0 (bubble); pc unchanged.
    - !ack & stall_i: IF/ID holds; pc unchanged.
  - HOLD: req=0.
    - !stall_i: IF/ID <= {valid=1, buffer}; go to REQ.
    - stall_i: everything holds.
- Redirect: branch_taken_i overrides all of the above, in any state including IDLE and regardless of stall_i.
  - pc <= branch_target_i.
  - if_id_valid_o <= 0. if_id_pc_o and if_id_instr_o may keep stale values.
  - Buffer discarded.
  - Any same-cycle ack data discarded.
  - Next state REQ; first request for the target is issued the next cycle.
- pc+4 is modulo 2^PC_WIDTH: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- branch_target_i is used unaligned as given; no alignment check.
- IF/ID latency: instruction appears on if_id_* the cycle after its ack when not stalled.
- ID must gate RegWrite/MemWrite/MemRead/Branch with if_id_valid_o. An opcode of 0 decodes as R-format and must not write back.

Test Plan:
- Reset then zero-wait memory (ack whenever req), rdata = 0x8B000000|addr:
  - IDLE for 1 cycle.
  - Then if_id_pc_o = 0, 4, 8, 12 on consecutive cycles.
  - if_id_opcode_o = 11'h458 throughout, valid=1 throughout.
- Memory acks every 3rd req cycle, no stall:
  - Two bubble cycles (valid=0) between instructions.
  - PCs strictly 0, 4, 8 with no skips or duplicates.
- stall_i high for 4 cycles coinciding with ack at pc=8:
  - IF/ID holds pc=4; req drops in HOLD; pc_o=12.
  - On release, if_id_pc_o=8 next cycle, then 12.
- branch_taken_i with target 0x100 while in HOLD with stall_i=1:
  - Next cycle valid=0, buffer lost, req=1, addr=0x100.
  - Instr 0x100 reaches IF/ID once unstalled; instr 8 is never seen.
- branch_taken_i in the same cycle as an ack at pc=0x20, target 0x400:
  - 0x20 never appears in IF/ID; next fetched PC is 0x400.
- RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC, zero-wait memory:
  - Fetch order FFFC then 0.
  - Reset pulsed mid-run: outputs clear asynchronously; refetch starts at RESET_PC.
